seg_scan_mux: RTL and testbench
===============================

SEG_SCAN_MUX -- requirements
Module: seg_scan_mux

Interface
REQ-001 SHALL have parameter NUM_DIGITS, default 8, number of multiplexed digits (legal 1..16).
REQ-002 SHALL have parameter TICK_DIV, default 100000, clock cycles per digit slot (legal ≥ BLANK_CYCLES+2).
REQ-003 SHALL have parameter BLANK_CYCLES, default 16, anti-ghosting blank cycles at the start of each slot (legal ≥ 1).
REQ-004 SHALL have parameter ACTIVE_LOW, default 1; 1 = an, seg and dp driven active-low.
REQ-005 SHALL have ports clk input 1 system clock; rst input 1 reset, synchronous, active-high.
REQ-006 SHALL have ports en input 1 scan enable; data input 4*NUM_DIGITS hex nibbles, digit 0 in [3:0]; dp_in input NUM_DIGITS per-digit decimal point.
REQ-007 SHALL have ports an output NUM_DIGITS digit enables; seg output 7 segments {g,f,e,d,c,b,a}; dp output 1 decimal point.
REQ-008 SHALL have ports digit_idx output max(1,$clog2(NUM_DIGITS)) current slot index; frame_done output 1 end-of-frame pulse.

Function
REQ-009 SHALL run prescaler 0..TICK_DIV-1, wrapping to 0; on wrap digit_idx SHALL advance, NUM_DIGITS-1 wrapping to 0.
REQ-010 SHALL implement two-state slot FSM: BLANK (prescaler < BLANK_CYCLES) -> SHOW (prescaler ≥ BLANK_CYCLES) -> BLANK on slot wrap.
REQ-011 In BLANK, all an bits, seg bits and dp SHALL be inactive.
REQ-012 In SHOW, only an[digit_idx] SHALL be active; seg = hex decode of snapshot nibble digit_idx; dp = snapshot dp_in[digit_idx].
REQ-013 Outputs an, seg, dp, frame_done SHALL be registered: one-cycle latency from prescaler/FSM state.
REQ-014 Snapshot registers SHALL load data and dp_in when prescaler==0 and digit_idx==0; a frame SHALL never mix old and new data.
REQ-015 frame_done SHALL pulse exactly one cycle, the cycle after prescaler==TICK_DIV-1 with digit_idx==NUM_DIGITS-1.
REQ-016 Hex decode SHALL cover 0-F (lowercase b,d glyphs); ACTIVE_LOW inverts an, seg, dp only, never internal state.
REQ-017 en low SHALL clear prescaler, digit_idx, FSM to BLANK and drive outputs inactive next cycle; en high resumes exactly as after reset.
REQ-018 NUM_DIGITS==1 SHALL keep digit_idx at 0 and still pulse frame_done every TICK_DIV cycles.

Reset
REQ-019 rst SHALL, on the next clock edge regardless of en or mid-slot state, set prescaler 0, digit_idx 0, FSM BLANK, snapshot 0, an/seg/dp inactive, frame_done 0.
REQ-020 The first cycle with rst low SHALL be cycle 0 of slot 0 (snapshot load, BLANK).

Configuration
REQ-021 With SEG_SCAN_LZS_EN defined, leading-zero suppression SHALL apply: digits above the most-significant non-zero snapshot nibble keep an inactive during SHOW, unless that digit's snapshot dp bit is set; digit 0 always shows.
REQ-022 Without SEG_SCAN_LZS_EN, all digits SHALL be shown; no suppression logic compiled.

Structure
REQ-023 Package seg_scan_pkg SHALL hold the 16-entry hex-to-segment constant table and SEG_OFF constant.
REQ-024 Sub-module seg_hex_decode (4-bit in, 7-bit active-high out, combinational) SHALL be instantiated once.

Verification (NUM_DIGITS=4, TICK_DIV=8, BLANK_CYCLES=2, ACTIVE_LOW=1)
REQ-025 rst high 3 cycles mid-slot -> an=4'b1111, seg=7'h7F, dp=1, frame_done=0, digit_idx=0.
REQ-026 data=16'h1234, dp_in=4'b0001 -> slot 0: an=1111 for 2 cycles then 1110 for 6, seg=7'h19, dp=0; slot 1 seg=7'h30.
REQ-027 Free run -> frame_done one-cycle pulse every 32 cycles, digit_idx sequence 0,1,2,3,0.
REQ-028 data 16'h1234 -> 16'hABCD at cycle 10 of frame -> digits 1-3 of that frame still show 3,2,1; next frame shows D,C,B,A.
REQ-029 en low during slot 2 SHOW -> an=1111 next cycle, digit_idx=0; en high -> 2 blank cycles then an=1110.
REQ-030 data=16'h0050: with SEG_SCAN_LZS_EN -> an[3], an[2] never active, digit 0 seg=7'h40 shown; without -> all four anodes active in turn.

Source files
------------

// File: rtl/seg_scan_pkg.sv
// Shared constants for the seven-segment scan multiplexer.
// Segment order is {g,f,e,d,c,b,a}. All values here are active-high.
package seg_scan_pkg;

    // All segments dark, internal polarity
    localparam logic [6:0] SEG_OFF = 7'h00;

    // Hex glyph table, entry [n] is the glyph for nibble n (lowercase b and d)
    localparam logic [15:0][6:0] HEX_SEG = {
        7'h71, 7'h79, 7'h5E, 7'h39, 7'h7C, 7'h77, 7'h6F, 7'h7F,
        7'h07, 7'h7D, 7'h6D, 7'h66, 7'h4F, 7'h5B, 7'h06, 7'h3F
    };

    // Slot phase: anti-ghosting blank window, then digit display window
    typedef enum logic {
        SLOT_BLANK = 1'b0,
        SLOT_SHOW  = 1'b1
    } slot_state_e;

    // Glyph lookup
    function automatic logic [6:0] hex_to_seg(input logic [3:0] nib);
        return HEX_SEG[nib];
    endfunction

endpackage

// File: rtl/seg_hex_decode.sv
// Combinational hex nibble to active-high seven-segment glyph.
module seg_hex_decode
    import seg_scan_pkg::*;
(
    input  logic [3:0] nib,
    output logic [6:0] seg_c
);

    // Table lookup
    always_comb begin
        seg_c = hex_to_seg(nib);
    end

endmodule

// File: rtl/seg_scan_mux.sv
// Time-multiplexed seven-segment display scanner.
// Each digit slot lasts TICK_DIV cycles: BLANK_CYCLES dark, then the digit.
// Digit data is snapshotted at the start of every frame so a frame never
// mixes old and new values.
// Optional build macro SEG_SCAN_LZS_EN enables leading-zero suppression.
module seg_scan_mux
    import seg_scan_pkg::*;
#(
    parameter int unsigned NUM_DIGITS   = 8,
    parameter int unsigned TICK_DIV     = 100000,
    parameter int unsigned BLANK_CYCLES = 16,
    parameter int unsigned ACTIVE_LOW   = 1
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          en,
    input  logic [4*NUM_DIGITS-1:0]       data,
    input  logic [NUM_DIGITS-1:0]         dp_in,
    output logic [NUM_DIGITS-1:0]         an,
    output logic [6:0]                    seg,
    output logic                          dp,
    output logic [((NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1)-1:0] digit_idx,
    output logic                          frame_done
);

    localparam int unsigned IDX_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
    localparam int unsigned PSC_W = $clog2(TICK_DIV);

    localparam logic [PSC_W-1:0] PSC_LAST   = PSC_W'(TICK_DIV - 1);
    localparam logic [PSC_W-1:0] BLANK_LAST = PSC_W'(BLANK_CYCLES - 1);
    localparam logic [IDX_W-1:0] IDX_LAST   = IDX_W'(NUM_DIGITS - 1);
    localparam logic             POL        = (ACTIVE_LOW != 0);

    logic [PSC_W-1:0]               psc_q;
    logic                           psc_wrap;
    logic                           last_slot;
    slot_state_e                    state_q;
    slot_state_e                    state_d;
    logic [NUM_DIGITS-1:0][3:0]     snap_q;
    logic [NUM_DIGITS-1:0]          snap_dp_q;
    logic [3:0]                     cur_nib;
    logic [6:0]                     dec_seg;
    logic [NUM_DIGITS-1:0]          keep_c;
    logic [NUM_DIGITS-1:0]          an_c;
    logic [6:0]                     seg_c;
    logic                           dp_c;
    logic                           fd_c;

    assign psc_wrap  = (psc_q == PSC_LAST);
    assign last_slot = (digit_idx == IDX_LAST);

    // Prescaler and slot index; disable parks both at the start of slot 0
    always_ff @(posedge clk) begin
        if (rst || !en) begin
            psc_q     <= '0;
            digit_idx <= '0;
        end else if (psc_wrap) begin
            psc_q     <= '0;
            digit_idx <= last_slot ? '0 : digit_idx + IDX_W'(1);
        end else begin
            psc_q     <= psc_q + PSC_W'(1);
        end
    end

    // Frame snapshot, captured on the first cycle of slot 0
    always_ff @(posedge clk) begin
        if (rst) begin
            snap_q    <= '0;
            snap_dp_q <= '0;
        end else if (en && (psc_q == '0) && (digit_idx == '0)) begin
            snap_q    <= data;
            snap_dp_q <= dp_in;
        end
    end

    // Slot FSM state register
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= SLOT_BLANK;
        end else begin
            state_q <= state_d;
        end
    end

    // Slot FSM next state: leave BLANK after the blank window, return on slot wrap
    always_comb begin
        state_d = state_q;
        if (!en) begin
            state_d = SLOT_BLANK;
        end else begin
            case (state_q)
                SLOT_BLANK: if (psc_q == BLANK_LAST) state_d = SLOT_SHOW;
                SLOT_SHOW:  if (psc_wrap)            state_d = SLOT_BLANK;
                default:                             state_d = SLOT_BLANK;
            endcase
        end
    end

    assign cur_nib = snap_q[digit_idx];

    seg_hex_decode u_dec (
        .nib   (cur_nib),
        .seg_c (dec_seg)
    );

`ifdef SEG_SCAN_LZS_EN
    logic nz_above;

    // Digits above the top non-zero nibble stay dark unless their dp is set
    always_comb begin
        nz_above = 1'b0;
        keep_c   = '0;
        for (int i = int'(NUM_DIGITS) - 1; i >= 0; i--) begin
            nz_above  = nz_above | (snap_q[i] != 4'h0);
            keep_c[i] = nz_above | snap_dp_q[i] | (i == 0);
        end
    end
`else
    // Every digit is shown
    assign keep_c = '1;
`endif

    // Output decode from current FSM state, internal active-high polarity
    always_comb begin
        an_c  = '0;
        seg_c = SEG_OFF;
        dp_c  = 1'b0;
        fd_c  = en && psc_wrap && last_slot;
        if (en && (state_q == SLOT_SHOW)) begin
            an_c[digit_idx] = keep_c[digit_idx];
            seg_c           = dec_seg;
            dp_c            = snap_dp_q[digit_idx];
        end
    end

    // Registered pins with board polarity applied
    always_ff @(posedge clk) begin
        if (rst) begin
            an         <= {NUM_DIGITS{POL}};
            seg        <= SEG_OFF ^ {7{POL}};
            dp         <= POL;
            frame_done <= 1'b0;
        end else begin
            an         <= an_c ^ {NUM_DIGITS{POL}};
            seg        <= seg_c ^ {7{POL}};
            dp         <= dp_c ^ POL;
            frame_done <= fd_c;
        end
    end

endmodule

// File: tb/tb_seg_scan_mux.sv
// Bench for seg_scan_mux with NUM_DIGITS=4, TICK_DIV=8, BLANK_CYCLES=2, ACTIVE_LOW=1.
module tb_seg_scan_mux;

    localparam int ND = 4;
    localparam int TD = 8;
    localparam int BC = 2;

    logic        clk = 1'b0;
    logic        rst;
    logic        en;
    logic [15:0] data;
    logic [3:0]  dp_in;
    logic [3:0]  an;
    logic [6:0]  seg;
    logic        dp;
    logic [1:0]  digit_idx;
    logic        frame_done;

    always #5 clk = ~clk;

    seg_scan_mux #(
        .NUM_DIGITS   (ND),
        .TICK_DIV     (TD),
        .BLANK_CYCLES (BC),
        .ACTIVE_LOW   (1)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .en         (en),
        .data       (data),
        .dp_in      (dp_in),
        .an         (an),
        .seg        (seg),
        .dp         (dp),
        .digit_idx  (digit_idx),
        .frame_done (frame_done)
    );

    typedef struct packed {
        logic [3:0] an;
        logic [6:0] seg;
        logic       dp;
        logic       fd;
        logic [1:0] idx;
    } obs_t;

    typedef struct {
        logic [15:0] data;
        logic [3:0]  dpi;
        int          slot;
        logic [3:0]  an;
        logic [6:0]  seg;
        logic        dp;
    } vec_t;

    int          n_tests = 0;
    int          n_fail  = 0;
    int          cyc     = 0;
    obs_t        sb_q[$];
    vec_t        vecs[8];

    int          m_psc  = 0;
    int          m_idx  = 0;
    logic [15:0] m_snap = '0;
    logic [3:0]  m_sdp  = '0;

    // Active-high glyphs, {g,f,e,d,c,b,a}
    function automatic logic [6:0] seg_of(input logic [3:0] n);
        case (n)
            4'h0: return 7'h3F; 4'h1: return 7'h06; 4'h2: return 7'h5B; 4'h3: return 7'h4F;
            4'h4: return 7'h66; 4'h5: return 7'h6D; 4'h6: return 7'h7D; 4'h7: return 7'h07;
            4'h8: return 7'h7F; 4'h9: return 7'h6F; 4'hA: return 7'h77; 4'hB: return 7'h7C;
            4'hC: return 7'h39; 4'hD: return 7'h5E; 4'hE: return 7'h79; default: return 7'h71;
        endcase
    endfunction

    // Which digits may light their anode in the current frame
    function automatic logic [3:0] keep_mask(input logic [15:0] s, input logic [3:0] d);
`ifdef SEG_SCAN_LZS_EN
        int         msnz;
        logic [3:0] k;
        msnz = 0;
        for (int i = 0; i < ND; i++)
            if (s[4*i +: 4] != 4'h0) msnz = i;
        for (int i = 0; i < ND; i++)
            k[i] = (i <= msnz) || d[i];
        return k;
`else
        return (s == s) ? 4'hF : d;
`endif
    endfunction

    task automatic chk(input string name, input int got, input int exp);
        n_tests++;
        if (got != exp) begin
            n_fail++;
            $display("FAIL %s cyc=%0d got=%h exp=%h", name, cyc, got, exp);
        end
    endtask

    // One clock: predict post-edge outputs from the model, advance, compare
    task automatic tick();
        obs_t       e;
        obs_t       got;
        logic [3:0] k;
        if (rst || !en || m_psc < BC) begin
            e.an  = 4'hF;
            e.seg = 7'h7F;
            e.dp  = 1'b1;
        end else begin
            k     = keep_mask(m_snap, m_sdp);
            e.an  = ~((4'b0001 << m_idx) & k);
            e.seg = ~seg_of(m_snap[4*m_idx +: 4]);
            e.dp  = ~m_sdp[m_idx];
        end
        e.fd = !rst && en && (m_psc == TD - 1) && (m_idx == ND - 1);
        if (rst) begin
            m_psc = 0; m_idx = 0; m_snap = '0; m_sdp = '0;
        end else if (!en) begin
            m_psc = 0; m_idx = 0;
        end else begin
            if (m_psc == 0 && m_idx == 0) begin
                m_snap = data;
                m_sdp  = dp_in;
            end
            if (m_psc == TD - 1) begin
                m_psc = 0;
                m_idx = (m_idx == ND - 1) ? 0 : m_idx + 1;
            end else begin
                m_psc = m_psc + 1;
            end
        end
        e.idx = 2'(m_idx);
        sb_q.push_back(e);
        @(posedge clk);
        #1;
        cyc++;
        got = {an, seg, dp, frame_done, digit_idx};
        e   = sb_q.pop_front();
        n_tests++;
        if (got !== e) begin
            n_fail++;
            $display("FAIL scoreboard cyc=%0d got an=%b seg=%h dp=%b fd=%b idx=%0d exp an=%b seg=%h dp=%b fd=%b idx=%0d",
                     cyc, got.an, got.seg, got.dp, got.fd, got.idx, e.an, e.seg, e.dp, e.fd, e.idx);
        end
    endtask

    task automatic do_reset(input int n);
        rst = 1'b1;
        repeat (n) tick();
        rst = 1'b0;
        cyc = 0;
    endtask

    task automatic run_to(input int c);
        while (cyc < c) tick();
    endtask

    initial begin
        int pulses, first_p, second_p, t;
        int cnt0, cnt1, cnt2, cnt3, bad0;

        vecs[0] = '{16'h1234, 4'b0001, 0, 4'hE, 7'h19, 1'b0};
        vecs[1] = '{16'h1234, 4'b0001, 1, 4'hD, 7'h30, 1'b1};
        vecs[2] = '{16'h1234, 4'b0001, 3, 4'h7, 7'h79, 1'b1};
        vecs[3] = '{16'hABCD, 4'b0000, 0, 4'hE, 7'h21, 1'b1};
        vecs[4] = '{16'hABCD, 4'b0100, 2, 4'hB, 7'h03, 1'b0};
        vecs[5] = '{16'h8E0F, 4'b0000, 0, 4'hE, 7'h0E, 1'b1};
        vecs[6] = '{16'h8E0F, 4'b1000, 3, 4'h7, 7'h00, 1'b0};
        vecs[7] = '{16'h8E0F, 4'b0000, 1, 4'hD, 7'h40, 1'b1};

        rst = 1'b1; en = 1'b1; data = '0; dp_in = '0;

        // Reset held mid-slot
        do_reset(2);
        data = 16'h1234; dp_in = 4'b0001;
        run_to(13);
        rst = 1'b1;
        repeat (3) tick();
        chk("rst_an",  int'(an),         int'(4'hF));
        chk("rst_seg", int'(seg),        int'(7'h7F));
        chk("rst_dp",  int'(dp),         1);
        chk("rst_fd",  int'(frame_done), 0);
        chk("rst_idx", int'(digit_idx),  0);
        rst = 1'b0; cyc = 0;

        // Table of per-slot display vectors
        for (int v = 0; v < 8; v++) begin
            data = vecs[v].data; dp_in = vecs[v].dpi;
            do_reset(2);
            run_to(vecs[v].slot * TD + 5);
            chk($sformatf("vec%0d_an", v),  int'(an),  int'(vecs[v].an));
            chk($sformatf("vec%0d_seg", v), int'(seg), int'(vecs[v].seg));
            chk($sformatf("vec%0d_dp", v),  int'(dp),  int'(vecs[v].dp));
        end

        // Free run: frame pulse spacing and slot sequence
        data = 16'h1234; dp_in = 4'b0001;
        do_reset(2);
        pulses = 0; first_p = -1; second_p = -1;
        repeat (70) begin
            tick();
            if (frame_done) begin
                pulses++;
                if (first_p < 0) first_p = cyc; else if (second_p < 0) second_p = cyc;
            end
            if ((cyc % TD) == 4 && cyc < 40)
                chk("idx_seq", int'(digit_idx), (cyc / TD) % ND);
        end
        chk("fd_count",  pulses,   2);
        chk("fd_first",  first_p,  32);
        chk("fd_second", second_p, 64);

        // Data change mid-frame only appears next frame
        data = 16'h1234; dp_in = 4'b0000;
        do_reset(2);
        run_to(10);
        data = 16'hABCD;
        run_to(13); chk("old_d1", int'(seg), int'(7'h30));
        run_to(21); chk("old_d2", int'(seg), int'(7'h24));
        run_to(29); chk("old_d3", int'(seg), int'(7'h79));
        run_to(37); chk("new_d0", int'(seg), int'(7'h21));
        run_to(45); chk("new_d1", int'(seg), int'(7'h46));
        run_to(53); chk("new_d2", int'(seg), int'(7'h03));
        run_to(61); chk("new_d3", int'(seg), int'(7'h08));

        // Disable during slot 2 display, then resume
        data = 16'h1234; dp_in = 4'b0001;
        do_reset(2);
        run_to(20);
        chk("pre_dis_an", int'(an), int'(4'hB));
        en = 1'b0;
        tick();
        chk("dis_an",  int'(an),        int'(4'hF));
        chk("dis_idx", int'(digit_idx), 0);
        tick(); tick();
        en = 1'b1;
        t = 0;
        tick(); chk("res_blank0", int'(an), int'(4'hF));
        tick(); chk("res_blank1", int'(an), int'(4'hF));
        tick(); chk("res_show_an",  int'(an),  int'(4'hE));
        chk("res_show_seg", int'(seg), int'(7'h19));

        // Leading zeros
        data = 16'h0050; dp_in = 4'b0000;
        do_reset(2);
        cnt0 = 0; cnt1 = 0; cnt2 = 0; cnt3 = 0; bad0 = 0;
        repeat (ND * TD) begin
            tick();
            if (!an[0]) begin cnt0++; if (seg != 7'h40) bad0++; end
            if (!an[1]) cnt1++;
            if (!an[2]) cnt2++;
            if (!an[3]) cnt3++;
        end
        chk("lz_an0", cnt0, TD - BC);
        chk("lz_seg0", bad0, 0);
        chk("lz_an1", cnt1, TD - BC);
`ifdef SEG_SCAN_LZS_EN
        chk("lz_an2", cnt2, 0);
        chk("lz_an3", cnt3, 0);
`else
        chk("lz_an2", cnt2, TD - BC);
        chk("lz_an3", cnt3, TD - BC);
`endif

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
